update_dispatcher: RTL

- Initiator side of the graph-update/container handshake.
- Accepts edge-weight updates from the host write interface into a FIFO.
- Presents one update at a time on u_src/u_dst/u_e, pulses container_reset, and waits for container_done before it issues the next update.
- Serialises host traffic so each update triggers exactly one full update, Bellman, cycle-detect and print pass.

---
 rtl/update_dispatcher.sv | 94 +++++++++
 1 files changed

// File: rtl/update_dispatcher.sv
// update_dispatcher: FIFO-buffered initiator that issues one graph update per container pass
// Ports: clk, reset (sync active-high); host side wr_valid/wr_src/wr_dst/wr_e/wr_ready;
//   container side u_src/u_dst/u_e (held update), container_reset (start pulse), container_done (level);
//   status busy, fifo_count (occupancy), done_count (completed, wraps), drop_count (rejected, saturates).
//   Define COALESCE_EN to merge a write into the newest queued entry with the same (src,dst).
module update_dispatcher #(
  parameter int PRED_W   = 6,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [PRED_W-1:0]      wr_src,
  input  logic [PRED_W-1:0]      wr_dst,
  input  logic [WEIGHT_W-1:0]    wr_e,
  output logic                   wr_ready,
  output logic [PRED_W-1:0]      u_src,
  output logic [PRED_W-1:0]      u_dst,
  output logic [WEIGHT_W-1:0]    u_e,
  output logic                   container_reset,
  input  logic                   container_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       done_count,
  output logic [CNT_W-1:0]       drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, PULSE, ARM, WAIT} state_t;
  state_t state;
  logic [PRED_W-1:0] mem_src [DEPTH];
  logic [PRED_W-1:0] mem_dst [DEPTH];
  logic [WEIGHT_W-1:0] mem_e [DEPTH];
  logic [AW-1:0] head, tail, last;
  logic pop, push, coal;
  assign last = tail - AW'(1);
  assign pop = (state == IDLE) && (fifo_count != '0);
`ifdef COALESCE_EN
  logic tail_match;
  assign tail_match = (fifo_count != '0) && (mem_src[last] == wr_src) && (mem_dst[last] == wr_dst);
  assign wr_ready = ((fifo_count < FULL) || tail_match) && !reset;
  assign coal = wr_valid && tail_match && !(pop && (fifo_count == (AW+1)'(1)));
`else
  assign wr_ready = (fifo_count < FULL) && !reset;
  assign coal = 1'b0;
`endif
  assign push = wr_valid && wr_ready && !coal;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      fifo_count <= '0;
      state <= IDLE;
      u_src <= '0;
      u_dst <= '0;
      u_e <= '0;
      container_reset <= 1'b0;
      busy <= 1'b0;
      done_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem_src[tail] <= wr_src;
        mem_dst[tail] <= wr_dst;
        mem_e[tail] <= wr_e;
        tail <= tail + AW'(1);
      end
      if (coal) mem_e[last] <= wr_e;
      if (pop) head <= head + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (wr_valid && !wr_ready && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      container_reset <= 1'b0;
      unique case (state)
        IDLE: if (pop) begin
          u_src <= mem_src[head];
          u_dst <= mem_dst[head];
          u_e <= mem_e[head];
          container_reset <= 1'b1;
          busy <= 1'b1;
          state <= PULSE;
        end
        PULSE: state <= ARM;
        ARM: state <= WAIT;
        WAIT: if (container_done) begin
          busy <= 1'b0;
          done_count <= done_count + CNT_W'(1);
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
